srrc_rate_ctrl: RTL and testbench

Rate and configuration controller for the SRRC transmit/receive filter chain. It divides the system clock into the one-cycle `sam_clk_en` and `sym_clk_en` strobes that drive the filter delay lines and symbol logic. It applies filter-select (`sw`) changes only on symbol boundaries. After reset or any filter-select change it tracks the filter fill period and asserts `out_valid` only once the 81-tap delay line holds data produced entirely under the current configuration.

---
 rtl/srrc_rate_ctrl.sv | 135 +++++++++++++
 tb/tb_srrc_rate_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/srrc_rate_ctrl.sv
// srrc_rate_ctrl: rate and configuration controller for the SRRC filter chain.
// Divides clk into one-cycle sample/symbol strobes, applies the filter select
// only on symbol boundaries, and flags out_valid once the delay line has been
// refilled with NTAPS samples taken under the current select.
//
// Ports:
//   clk        - system clock, rising edge
//   reset_n    - asynchronous active-low reset
//   enable     - run control; 0 freezes counters, select and FSM
//   sw_req     - requested filter/coefficient select
//   sam_clk_en - one-cycle sample strobe (registered)
//   sym_clk_en - one-cycle symbol strobe, coincident with a sample strobe
//   sam_phase  - sample index within the current symbol
//   sw_active  - select currently applied to the filter
//   out_valid  - filter output is meaningful
module srrc_rate_ctrl #(
    parameter int unsigned CLK_PER_SAM = 4,
    parameter int unsigned SAM_PER_SYM = 4,
    parameter int unsigned NTAPS       = 81
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           enable,
    input  logic [1:0]                     sw_req,
    output logic                           sam_clk_en,
    output logic                           sym_clk_en,
    output logic [$clog2(SAM_PER_SYM)-1:0] sam_phase,
    output logic [1:0]                     sw_active,
    output logic                           out_valid
);

    localparam int unsigned CW = $clog2(CLK_PER_SAM);
    localparam int unsigned SW = $clog2(SAM_PER_SYM);
    localparam int unsigned FW = $clog2(NTAPS + 1);

    typedef enum logic {
        S_FILL = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   clk_cnt_q, clk_cnt_d;
    logic [SW-1:0]   sam_cnt_q, sam_cnt_d;
    logic [FW-1:0]   fill_cnt_q, fill_cnt_d;
    logic            sam_clk_en_q, sym_clk_en_q;
    logic [1:0]      sw_active_q, sw_active_d;
    logic            out_valid_q, out_valid_d;

    logic            tick_c;
    logic            sym_tick_c;
    logic            cfg_change_c;
    logic            fill_done_c;

    // Strobe decode: tick_c is the edge that raises sam_clk_en.
    assign tick_c       = enable && (clk_cnt_q == CW'(CLK_PER_SAM - 1));
    assign sym_tick_c   = tick_c && (sam_cnt_q == SW'(SAM_PER_SYM - 1));
    assign cfg_change_c = sym_tick_c && (sw_req != sw_active_q);
    // Counting uses the registered strobe, so a strobe issued just before
    // enable drops is still counted and never lost from the fill.
    assign fill_done_c  = sam_clk_en_q && (fill_cnt_q == FW'(NTAPS - 1));

    // Clock/sample divider and select latch next-state.
    always_comb begin
        clk_cnt_d   = clk_cnt_q;
        sam_cnt_d   = sam_cnt_q;
        sw_active_d = sw_active_q;
        if (enable) begin
            clk_cnt_d = tick_c ? '0 : clk_cnt_q + CW'(1);
        end
        if (tick_c) begin
            sam_cnt_d = (sam_cnt_q == SW'(SAM_PER_SYM - 1)) ? '0 : sam_cnt_q + SW'(1);
        end
        if (sym_tick_c) begin
            sw_active_d = sw_req;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_FILL;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; a config change overrides fill completion.
    always_comb begin
        state_d = state_q;
        if (cfg_change_c) begin
            state_d = S_FILL;
        end else if ((state_q == S_FILL) && fill_done_c) begin
            state_d = S_RUN;
        end
    end

    // FSM outputs: fill counter and valid flag next values.
    always_comb begin
        fill_cnt_d  = fill_cnt_q;
        out_valid_d = (state_d == S_RUN);
        if (cfg_change_c) begin
            fill_cnt_d = '0;
        end else if ((state_q == S_FILL) && sam_clk_en_q) begin
            fill_cnt_d = fill_cnt_q + FW'(1);
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clk_cnt_q    <= '0;
            sam_cnt_q    <= '0;
            fill_cnt_q   <= '0;
            sam_clk_en_q <= 1'b0;
            sym_clk_en_q <= 1'b0;
            sw_active_q  <= 2'b00;
            out_valid_q  <= 1'b0;
        end else begin
            clk_cnt_q    <= clk_cnt_d;
            sam_cnt_q    <= sam_cnt_d;
            fill_cnt_q   <= fill_cnt_d;
            sam_clk_en_q <= tick_c;
            sym_clk_en_q <= sym_tick_c;
            sw_active_q  <= sw_active_d;
            out_valid_q  <= out_valid_d;
        end
    end

    assign sam_clk_en = sam_clk_en_q;
    assign sym_clk_en = sym_clk_en_q;
    assign sam_phase  = sam_cnt_q;
    assign sw_active  = sw_active_q;
    assign out_valid  = out_valid_q;

endmodule

// File: tb/tb_srrc_rate_ctrl.sv
// Testbench for srrc_rate_ctrl: directed timeline tables plus randomized
// enable/select stimulus, all checked against an arithmetic reference model.
module tb_srrc_rate_ctrl;

    localparam int unsigned CPS = 4;
    localparam int unsigned SPS = 4;
    localparam int unsigned NT  = 81;

    logic       clk     = 1'b0;
    logic       reset_n = 1'b1;
    logic       enable  = 1'b0;
    logic [1:0] sw_req  = 2'b00;
    logic       sam_clk_en;
    logic       sym_clk_en;
    logic [1:0] sam_phase;
    logic [1:0] sw_active;
    logic       out_valid;

    srrc_rate_ctrl #(
        .CLK_PER_SAM(CPS),
        .SAM_PER_SYM(SPS),
        .NTAPS      (NT)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .enable    (enable),
        .sw_req    (sw_req),
        .sam_clk_en(sam_clk_en),
        .sym_clk_en(sym_clk_en),
        .sam_phase (sam_phase),
        .sw_active (sw_active),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    int vec_cnt = 0;
    int err_cnt = 0;
    int edge_no = 0;
    int pulses  = 0;

    // Reference model: m_e counts enabled edges since reset; strobes and phase
    // follow from it arithmetically. m_fill counts strobes seen since restart.
    int         m_e;
    bit         m_sam;
    bit         m_sym;
    int         m_phase;
    logic [1:0] m_sw;
    int         m_fill;
    bit         m_valid;

    typedef struct {
        int         at_edge;
        bit         en_after;
        logic [1:0] req_after;
        logic [6:0] exp;
        string      name;
    } vec_t;

    vec_t tbl[$];

    function automatic void model_reset();
        m_e = 0; m_sam = 0; m_sym = 0; m_phase = 0;
        m_sw = 2'b00; m_fill = 0; m_valid = 0;
    endfunction

    function automatic void model_edge(input bit en, input logic [1:0] req);
        bit prev_sam;
        bit restart;
        prev_sam = m_sam;
        m_sam = 0;
        m_sym = 0;
        if (en) begin
            m_e++;
            m_sam = ((m_e % CPS) == 0);
            m_sym = ((m_e % (CPS * SPS)) == 0);
        end
        m_phase = (m_e / CPS) % SPS;
        restart = m_sym && (req != m_sw);
        if (m_sym) m_sw = req;
        if (restart) begin
            m_fill  = 0;
            m_valid = 0;
        end else if (prev_sam && !m_valid) begin
            m_fill++;
            if (m_fill == NT) m_valid = 1;
        end
    endfunction

    function automatic logic [6:0] dut_vec();
        return {sam_clk_en, sym_clk_en, sam_phase, sw_active, out_valid};
    endfunction

    function automatic logic [6:0] model_vec();
        return {m_sam, m_sym, 2'(m_phase), m_sw, m_valid};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s @edge %0d: got 0x%0h, expected 0x%0h", name, edge_no, act, exp);
        end
    endtask

    // One rising edge; model sees the inputs held across that edge.
    task automatic step();
        @(posedge clk);
        model_edge(enable, sw_req);
        edge_no++;
        #1;
        check("model", 32'(dut_vec()), 32'(model_vec()));
        if (sam_clk_en && !out_valid) pulses++;
    endtask

    // Asserts reset between edges and checks outputs clear without a clock.
    task automatic do_reset(input logic [1:0] req);
        reset_n = 1'b0;
        #2;
        check("async_reset", 32'(dut_vec()), 32'd0);
        model_reset();
        enable = 1'b1;
        sw_req = req;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        edge_no = 0;
        pulses  = 0;
    endtask

    task automatic add(input int e, input bit en, input logic [1:0] req,
                       input logic [6:0] exp, input string name);
        vec_t v;
        v.at_edge = e; v.en_after = en; v.req_after = req; v.exp = exp; v.name = name;
        tbl.push_back(v);
    endtask

    task automatic run_tbl();
        foreach (tbl[i]) begin
            while (edge_no < tbl[i].at_edge) step();
            check(tbl[i].name, 32'(dut_vec()), 32'(tbl[i].exp));
            enable = tbl[i].en_after;
            sw_req = tbl[i].req_after;
        end
        tbl.delete();
    endtask

    // Expected field order: {sam, sym, phase[1:0], sw_active[1:0], valid}
    initial begin
        #1;
        do_reset(2'b00);

        // Free run, fill latency, select change and ignored glitch.
        add(  1, 1, 2'b00, 7'b0_0_00_00_0, "a_e1");
        add(  4, 1, 2'b00, 7'b1_0_01_00_0, "a_e4");
        add(  5, 1, 2'b00, 7'b0_0_01_00_0, "a_e5");
        add(  8, 1, 2'b00, 7'b1_0_10_00_0, "a_e8");
        add( 12, 1, 2'b00, 7'b1_0_11_00_0, "a_e12");
        add( 16, 1, 2'b00, 7'b1_1_00_00_0, "a_e16");
        add( 17, 1, 2'b00, 7'b0_0_00_00_0, "a_e17");
        add( 20, 1, 2'b00, 7'b1_0_01_00_0, "a_e20");
        add( 32, 1, 2'b00, 7'b1_1_00_00_0, "a_e32");
        add(324, 1, 2'b00, 7'b1_0_01_00_0, "a_e324");
        add(325, 1, 2'b00, 7'b0_0_01_00_1, "a_e325");
        run_tbl();
        check("a_pulses", 32'(pulses), 32'd81);
        add(400, 1, 2'b01, 7'b1_1_00_00_1, "a_e400");
        add(415, 1, 2'b01, 7'b0_0_11_00_1, "a_e415");
        add(416, 1, 2'b01, 7'b1_1_00_01_0, "a_e416");
        add(420, 1, 2'b10, 7'b1_0_01_01_0, "a_e420");
        add(426, 1, 2'b01, 7'b0_0_10_01_0, "a_e426");
        add(432, 1, 2'b01, 7'b1_1_00_01_0, "a_e432");
        add(436, 1, 2'b01, 7'b1_0_01_01_0, "a_e436");
        add(736, 1, 2'b01, 7'b1_1_00_01_0, "a_e736");
        add(737, 1, 2'b01, 7'b0_0_00_01_1, "a_e737");
        run_tbl();

        // Enable low for edges 6..15: everything shifts by 10 edges.
        do_reset(2'b00);
        add(  4, 1, 2'b00, 7'b1_0_01_00_0, "b_e4");
        add(  5, 0, 2'b00, 7'b0_0_01_00_0, "b_e5");
        add( 10, 0, 2'b00, 7'b0_0_01_00_0, "b_e10");
        add( 15, 1, 2'b00, 7'b0_0_01_00_0, "b_e15");
        add( 16, 1, 2'b00, 7'b0_0_01_00_0, "b_e16");
        add( 18, 1, 2'b00, 7'b1_0_10_00_0, "b_e18");
        add( 26, 1, 2'b00, 7'b1_1_00_00_0, "b_e26");
        add(334, 1, 2'b00, 7'b1_0_01_00_0, "b_e334");
        add(335, 1, 2'b00, 7'b0_0_01_00_1, "b_e335");
        run_tbl();

        // Reset pulsed mid-fill with a non-zero select, then a clean refill.
        do_reset(2'b11);
        add( 16, 1, 2'b11, 7'b1_1_00_11_0, "c_e16");
        add(200, 1, 2'b00, 7'b1_0_10_11_0, "c_e200");
        run_tbl();
        do_reset(2'b00);
        add(324, 1, 2'b00, 7'b1_0_01_00_0, "c_e324");
        add(325, 1, 2'b00, 7'b0_0_01_00_1, "c_e325");
        run_tbl();

        // Randomized enable gaps and occasional select requests.
        do_reset(2'b00);
        for (int i = 0; i < 6000; i++) begin
            enable = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 299) == 0) sw_req = 2'($urandom);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
